// File: rtl/pkg_en.sv
// Shared ElectronNest token types and widths, plus the external bridge FSM states.
package pkg_en;

    localparam int WIDTH_DATA   = 32;
    localparam int WIDTH_EXADDR = 32;

    // Forward token: valid, acquirement, release, commit, index, data.
    typedef struct packed {
        logic                    v;
        logic                    a;
        logic                    r;
        logic                    c;
        logic [WIDTH_EXADDR-1:0] i;
        logic [WIDTH_DATA-1:0]   d;
    } FTk_t;

    // Backward token: n stalls the forward path, t is reserved.
    typedef struct packed {
        logic n;
        logic t;
    } BTk_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PROG,
        ST_DRAIN,
        ST_RUN
    } ext_bridge_st_t;

endpackage

// File: rtl/en_token_fifo2.sv
// Two-entry FTk_t FIFO; simultaneous push and pop is legal at any occupancy.
module en_token_fifo2
    import pkg_en::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  FTk_t       push_data,
    input  logic       pop,
    output FTk_t       head,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    FTk_t ent0;
    FTk_t ent1;
    logic pop_ok;
    logic push_ok;
    logic wr_slot1;

    assign empty    = (count == 2'd0);
    assign full     = (count == 2'd2);
    assign pop_ok   = pop & ~empty;
    assign push_ok  = push & (~full | pop_ok);
    // A push lands in slot 1 only when an entry remains in slot 0 after any pop.
    assign wr_slot1 = (count == 2'd2) | ((count == 2'd1) & ~pop_ok);
    assign head     = empty ? '0 : ent0;

    // Occupancy counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= 2'd0;
        end else begin
            count <= count + 2'(push_ok) - 2'(pop_ok);
        end
    end

    // Entry storage: slot 0 is always the head.
    always_ff @(posedge clock) begin
        if (push_ok && !wr_slot1) begin
            ent0 <= push_data;
        end else if (pop_ok && count == 2'd2) begin
            ent0 <= ent1;
        end
        if (push_ok && wr_slot1) begin
            ent1 <= push_data;
        end
    end

endmodule

// File: rtl/en_ext_mem_bridge.sv
// Bridges the ElectronNest external load/store ports to a 1-cycle-latency BRAM
// and plays out the boot stream (header tokens, then program words).
module en_ext_mem_bridge
    import pkg_en::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int WIDTH_MADDR = $clog2(MEM_DEPTH),
    parameter int BOOT_HDR    = 3,
    parameter int BOOT_LEN    = 5,
    parameter int EXT_IDX     = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    I_Boot,
    input  logic                    I_Ld_Req,
    input  logic [WIDTH_EXADDR-1:0] I_Ld_Addr,
    output logic                    O_Ld_Gnt,
    output FTk_t                    O_Ld_FTk,
    input  BTk_t                    I_Ld_BTk,
    input  logic                    I_St_Req,
    input  logic [WIDTH_EXADDR-1:0] I_St_Addr,
    input  FTk_t                    I_St_FTk,
    output BTk_t                    O_St_BTk,
    output logic                    O_Mem_En,
    output logic                    O_Mem_We,
    output logic [WIDTH_MADDR-1:0]  O_Mem_Addr,
    output logic [WIDTH_DATA-1:0]   O_Mem_WData,
    input  logic [WIDTH_DATA-1:0]   I_Mem_RData
);

    localparam int CNT_W = 16;

    ext_bridge_st_t state, state_nx;
    logic [CNT_W-1:0]        cnt, cnt_nx;
    logic                    boot_q;
    logic                    boot_rise;
    logic                    rd_vld_p1;
    logic [WIDTH_EXADDR-1:0] rd_addr_p1;
    logic                    issue;
    logic [WIDTH_EXADDR-1:0] issue_addr;
    logic                    hdr_push;
    logic                    credit;
    logic                    st_acc;
    FTk_t                    hdr_tok;
    FTk_t                    rd_tok;
    FTk_t                    fifo_din;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [1:0]              fifo_count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    unused_bits;

    assign unused_bits = ^{I_St_FTk, I_Ld_BTk, I_St_Addr};

    assign boot_rise = I_Boot & ~boot_q;
    assign fifo_pop  = O_Ld_FTk.v & ~I_Ld_BTk.n;
    // Credit counts the slot freed by this cycle's pop, so a draining
    // consumer sees back-to-back grants while a stalled one caps at two.
    assign credit = fifo_empty
                  | (~fifo_full & (~rd_vld_p1 | fifo_pop))
                  | (fifo_full & fifo_pop & ~rd_vld_p1);
    assign st_acc = (state == ST_RUN) & I_St_Req & I_St_FTk.v;

    always_comb begin
        hdr_tok   = '0;
        hdr_tok.v = 1'b1;
        hdr_tok.a = (cnt == '0);
        rd_tok    = '0;
        rd_tok.v  = 1'b1;
        rd_tok.d  = I_Mem_RData;
        rd_tok.i  = (EXT_IDX != 0) ? rd_addr_p1 : '0;
    end

    assign fifo_push = rd_vld_p1 | hdr_push;
    assign fifo_din  = rd_vld_p1 ? rd_tok : hdr_tok;

    // Store side is closed until the boot stream has fully drained; held
    // at zero while reset is asserted.
    always_comb begin
        O_St_BTk   = '0;
        O_St_BTk.n = ~reset & (state != ST_RUN);
    end

    // Control registers: FSM, boot counter, boot edge detector, read in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            boot_q    <= 1'b0;
            rd_vld_p1 <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            boot_q    <= I_Boot;
            rd_vld_p1 <= issue;
        end
    end

    // Address of the read in flight, used for the returned token index.
    always_ff @(posedge clock) begin
        if (issue) begin
            rd_addr_p1 <= issue_addr;
        end
    end

    // Next-state, BRAM command and grant decode; stores win over loads.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        hdr_push    = 1'b0;
        issue       = 1'b0;
        issue_addr  = '0;
        O_Ld_Gnt    = 1'b0;
        O_Mem_En    = 1'b0;
        O_Mem_We    = 1'b0;
        O_Mem_Addr  = '0;
        O_Mem_WData = '0;
        case (state)
            ST_IDLE: begin
                if (boot_rise) begin
                    state_nx = ST_HDR;
                    cnt_nx   = '0;
                end
            end
            ST_HDR: begin
                if (credit) begin
                    hdr_push = 1'b1;
                    if (cnt == CNT_W'(BOOT_HDR - 1)) begin
                        state_nx = ST_PROG;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            ST_PROG: begin
                if (credit) begin
                    issue      = 1'b1;
                    issue_addr = WIDTH_EXADDR'(cnt);
                    if (cnt == CNT_W'(BOOT_LEN - 1)) begin
                        state_nx = ST_DRAIN;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_count == 2'd0 && !rd_vld_p1) begin
                    state_nx = ST_RUN;
                end
            end
            ST_RUN: begin
                if (st_acc) begin
                    O_Mem_En    = 1'b1;
                    O_Mem_We    = 1'b1;
                    O_Mem_Addr  = I_St_Addr[WIDTH_MADDR-1:0];
                    O_Mem_WData = I_St_FTk.d;
                end else if (I_Ld_Req && credit) begin
                    O_Ld_Gnt   = 1'b1;
                    issue      = 1'b1;
                    issue_addr = I_Ld_Addr;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
        if (issue) begin
            O_Mem_En   = 1'b1;
            O_Mem_Addr = issue_addr[WIDTH_MADDR-1:0];
        end
    end

    en_token_fifo2 u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_din),
        .pop       (fifo_pop),
        .head      (O_Ld_FTk),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
